// File: rtl/ts_sync_recovery_mc_pkg.sv
// Shared constants for MPEG-2 TS sync recovery: sync byte value, packet lengths and FSM encodings.
// Combinational helper only; no timing or flow control of its own.
package ts_sync_recovery_mc_pkg;

    localparam logic [7:0] SYNC_BYTE   = 8'h47;
    localparam logic [7:0] PKT_LEN_188 = 8'd188;
    localparam logic [7:0] PKT_LEN_204 = 8'd204;

    localparam logic [1:0] ST_HUNT   = 2'd0;
    localparam logic [1:0] ST_VERIFY = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    function automatic logic [7:0] pkt_len(input logic mode_204);
        return mode_204 ? PKT_LEN_204 : PKT_LEN_188;
    endfunction

endpackage

// File: rtl/ts_sync_recovery_mc_channel.sv
// One TS channel: HUNT/VERIFY/LOCKED sync search with flywheel over missing syncs, loss counter.
// Latency 1 cycle byte-in to byte-out; no backpressure, cycles with i_byte_vld=0 freeze the channel.
module ts_sync_recovery_mc_channel
    import ts_sync_recovery_mc_pkg::*;
#(
    parameter int LOCK_CNT   = 3,
    parameter int UNLOCK_CNT = 3,
    parameter int CNT_W      = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_mode_204,
    input  logic [7:0]       i_byte,
    input  logic             i_byte_vld,
    output logic [7:0]       o_ts,
    output logic             o_valid,
    output logic             o_sync,
    output logic             o_locked,
    output logic [CNT_W-1:0] o_loss_cnt
);

    localparam int HITS_W = $clog2(LOCK_CNT + 1);
    localparam int MISS_W = $clog2(UNLOCK_CNT + 1);

    logic [1:0]        r_state;
    logic [7:0]        r_pos;
    logic [7:0]        r_len;
    logic [HITS_W-1:0] r_hits;
    logic [MISS_W-1:0] r_miss;
    logic [CNT_W-1:0]  r_loss;
    logic [7:0]        r_ts;
    logic              r_valid;
    logic              r_sync;
    logic              r_locked;

    logic [1:0]        w_state_nxt;
    logic [7:0]        w_pos_nxt;
    logic [7:0]        w_len_nxt;
    logic [HITS_W-1:0] w_hits_nxt;
    logic [MISS_W-1:0] w_miss_nxt;
    logic [CNT_W-1:0]  w_loss_nxt;
    logic              w_out_vld;
    logic              w_out_sync;

    logic              w_is_sync;
    logic              w_at_start;
    logic [7:0]        w_pos_wrap;
    logic [HITS_W-1:0] w_hits_inc;
    logic [MISS_W-1:0] w_miss_inc;

    assign w_is_sync  = (i_byte == SYNC_BYTE);
    assign w_at_start = (r_pos == 8'd0);
    assign w_pos_wrap = (r_pos == r_len - 8'd1) ? 8'd0 : r_pos + 8'd1;
    assign w_hits_inc = r_hits + HITS_W'(1);
    assign w_miss_inc = r_miss + MISS_W'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_pos_nxt   = r_pos;
        w_len_nxt   = r_len;
        w_hits_nxt  = r_hits;
        w_miss_nxt  = r_miss;
        w_loss_nxt  = r_loss;
        w_out_vld   = 1'b0;
        w_out_sync  = 1'b0;
        if (i_byte_vld) begin
            w_pos_nxt = w_pos_wrap;
            case (r_state)
                ST_HUNT: begin
                    if (w_is_sync) begin
                        // Packet length is frozen here until the channel next falls back to HUNT.
                        w_state_nxt = ST_VERIFY;
                        w_pos_nxt   = 8'd1;
                        w_hits_nxt  = HITS_W'(1);
                        w_len_nxt   = pkt_len(i_mode_204);
                    end else begin
                        w_pos_nxt = 8'd0;
                    end
                end
                ST_VERIFY: begin
                    if (w_at_start) begin
                        if (w_is_sync) begin
                            w_hits_nxt = w_hits_inc;
                            if (w_hits_inc == HITS_W'(LOCK_CNT)) begin
                                w_state_nxt = ST_LOCKED;
                                w_miss_nxt  = '0;
                                w_out_vld   = 1'b1;
                                w_out_sync  = 1'b1;
                            end
                        end else begin
                            w_state_nxt = ST_HUNT;
                            w_pos_nxt   = 8'd0;
                        end
                    end
                end
                ST_LOCKED: begin
                    w_out_vld  = 1'b1;
                    w_out_sync = w_at_start;
                    if (w_at_start) begin
                        if (w_is_sync) begin
                            w_miss_nxt = '0;
                        end else begin
                            w_miss_nxt = w_miss_inc;
                            // The byte that exhausts the miss budget is dropped, not forwarded.
                            if (w_miss_inc == MISS_W'(UNLOCK_CNT)) begin
                                w_state_nxt = ST_HUNT;
                                w_pos_nxt   = 8'd0;
                                w_out_vld   = 1'b0;
                                w_out_sync  = 1'b0;
                                w_loss_nxt  = (&r_loss) ? r_loss : r_loss + CNT_W'(1);
                            end
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_HUNT;
                    w_pos_nxt   = 8'd0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= ST_HUNT;
            r_pos    <= 8'd0;
            r_len    <= PKT_LEN_188;
            r_hits   <= '0;
            r_miss   <= '0;
            r_loss   <= '0;
            r_ts     <= 8'd0;
            r_valid  <= 1'b0;
            r_sync   <= 1'b0;
            r_locked <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_pos    <= w_pos_nxt;
            r_len    <= w_len_nxt;
            r_hits   <= w_hits_nxt;
            r_miss   <= w_miss_nxt;
            r_loss   <= w_loss_nxt;
            r_valid  <= w_out_vld;
            r_sync   <= w_out_sync;
            r_locked <= (w_state_nxt == ST_LOCKED);
            if (w_out_vld) begin
                r_ts <= i_byte;
            end
        end
    end

    assign o_ts       = r_ts;
    assign o_valid    = r_valid;
    assign o_sync     = r_sync;
    assign o_locked   = r_locked;
    assign o_loss_cnt = r_loss;

endmodule

// File: rtl/ts_sync_recovery_mc.sv
// N-channel MPEG-2 TS sync recovery; independent per-channel lock, sharing only the 188/204 mode select.
// Latency 1 cycle per channel; no backpressure, idle byte slots simply freeze that channel.
module ts_sync_recovery_mc #(
    parameter int NUM_CH     = 4,
    parameter int LOCK_CNT   = 3,
    parameter int UNLOCK_CNT = 3,
    parameter int CNT_W      = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_mode_204,
    input  logic [NUM_CH*8-1:0]     i_byte_in,
    input  logic [NUM_CH-1:0]       i_byte_valid,
    output logic [NUM_CH*8-1:0]     o_ts_out,
    output logic [NUM_CH-1:0]       o_valid_out,
    output logic [NUM_CH-1:0]       o_sync_out,
    output logic [NUM_CH-1:0]       o_locked,
    output logic [NUM_CH*CNT_W-1:0] o_sync_loss_cnt
);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        ts_sync_recovery_mc_channel #(
            .LOCK_CNT   (LOCK_CNT),
            .UNLOCK_CNT (UNLOCK_CNT),
            .CNT_W      (CNT_W)
        ) u_channel (
            .i_clk      (i_clk),
            .i_rst_n    (i_rst_n),
            .i_mode_204 (i_mode_204),
            .i_byte     (i_byte_in[g*8 +: 8]),
            .i_byte_vld (i_byte_valid[g]),
            .o_ts       (o_ts_out[g*8 +: 8]),
            .o_valid    (o_valid_out[g]),
            .o_sync     (o_sync_out[g]),
            .o_locked   (o_locked[g]),
            .o_loss_cnt (o_sync_loss_cnt[g*CNT_W +: CNT_W])
        );
    end

endmodule

// File: tb/tb_ts_sync_recovery_mc.sv
// Directed bench for ts_sync_recovery_mc (4 channels, defaults): lock, flywheel, loss, false sync, 204+gaps, reset.
module tb_ts_sync_recovery_mc;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 16;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b1;
    logic                    mode_204 = 1'b0;
    logic [NUM_CH*8-1:0]     byte_in = '0;
    logic [NUM_CH-1:0]       byte_valid = '0;
    logic [NUM_CH*8-1:0]     ts_out;
    logic [NUM_CH-1:0]       valid_out;
    logic [NUM_CH-1:0]       sync_out;
    logic [NUM_CH-1:0]       locked;
    logic [NUM_CH*CNT_W-1:0] loss_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ts_sync_recovery_mc #(
        .NUM_CH(NUM_CH), .LOCK_CNT(3), .UNLOCK_CNT(3), .CNT_W(CNT_W)
    ) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_mode_204      (mode_204),
        .i_byte_in       (byte_in),
        .i_byte_valid    (byte_valid),
        .o_ts_out        (ts_out),
        .o_valid_out     (valid_out),
        .o_sync_out      (sync_out),
        .o_locked        (locked),
        .o_sync_loss_cnt (loss_cnt)
    );

    function automatic logic [7:0] pay(int i);
        logic [7:0] x;
        x = 8'((i * 37 + 11) & 255);
        if (x == 8'h47) x = 8'h48;
        return x;
    endfunction

    task automatic drive(int c, logic [7:0] d, logic v);
        byte_in[c*8 +: 8] = d;
        byte_valid[c]     = v;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (valid_out !== 4'h0) begin n_bad++; $display("FAIL reset_valid got %h want 0", valid_out); end
        n_cmp++; if (sync_out !== 4'h0) begin n_bad++; $display("FAIL reset_sync got %h want 0", sync_out); end
        n_cmp++; if (locked !== 4'h0) begin n_bad++; $display("FAIL reset_locked got %h want 0", locked); end
        n_cmp++; if (ts_out !== 32'h0) begin n_bad++; $display("FAIL reset_ts got %h want 0", ts_out); end
        n_cmp++; if (loss_cnt !== 64'h0) begin n_bad++; $display("FAIL reset_loss got %h want 0", loss_cnt); end
        #2 rst_n = 1'b1;
        tick();
    endtask

    // ch0: clean 188-byte stream, lock on byte 0 of the third packet.
    task automatic test_clean_188();
        logic [7:0] d;
        logic [2:0] obs, ex;
        logic       ev;
        for (int p = 0; p < 5; p++) begin
            for (int k = 0; k < 188; k++) begin
                d = (k == 0) ? 8'h47 : pay(p * 188 + k);
                drive(0, d, 1'b1);
                tick();
                ev  = (p >= 2);
                ex  = {ev, ev && (k == 0), ev};
                obs = {valid_out[0], sync_out[0], locked[0]};
                n_cmp++;
                if (obs !== ex) begin
                    n_bad++; $display("FAIL clean188 p%0d k%0d vld/sync/lock got %b want %b", p, k, obs, ex);
                end
                if (ev) begin
                    n_cmp++;
                    if (ts_out[7:0] !== d) begin
                        n_bad++; $display("FAIL clean188_ts p%0d k%0d got %h want %h", p, k, ts_out[7:0], d);
                    end
                end
            end
        end
        drive(0, 8'h00, 1'b0);
    endtask

    // ch1: two corrupted syncs flywheel; a good sync clears miss so two more are tolerated.
    task automatic test_flywheel();
        logic [7:0] d;
        logic [2:0] obs, ex;
        logic       ev, bad;
        for (int p = 0; p < 10; p++) begin
            bad = (p == 4) || (p == 5) || (p == 7) || (p == 8);
            for (int k = 0; k < 188; k++) begin
                d = (k == 0) ? (bad ? 8'h00 : 8'h47) : pay(p * 188 + k + 3000);
                drive(1, d, 1'b1);
                tick();
                ev  = (p >= 2);
                ex  = {ev, ev && (k == 0), ev};
                obs = {valid_out[1], sync_out[1], locked[1]};
                n_cmp++;
                if (obs !== ex) begin
                    n_bad++; $display("FAIL flywheel p%0d k%0d vld/sync/lock got %b want %b", p, k, obs, ex);
                end
                if (ev && k == 0) begin
                    n_cmp++;
                    if (ts_out[15:8] !== d) begin
                        n_bad++; $display("FAIL flywheel_ts p%0d got %h want %h", p, ts_out[15:8], d);
                    end
                end
            end
        end
        drive(1, 8'h00, 1'b0);
        n_cmp++;
        if (loss_cnt[31:16] !== 16'd0) begin
            n_bad++; $display("FAIL flywheel_loss got %0d want 0", loss_cnt[31:16]);
        end
    endtask

    // ch2: three corrupted syncs in a row drop lock, then three good packets relock.
    task automatic test_loss_relock();
        logic [7:0] d;
        logic [2:0] obs, ex;
        logic       ev, bad;
        for (int p = 0; p < 11; p++) begin
            bad = (p >= 4) && (p <= 6);
            for (int k = 0; k < 188; k++) begin
                d = (k == 0) ? (bad ? 8'h00 : 8'h47) : pay(p * 188 + k + 7000);
                drive(2, d, 1'b1);
                tick();
                ev  = ((p >= 2) && (p <= 5)) || (p >= 9);
                ex  = {ev, ev && (k == 0), ev};
                obs = {valid_out[2], sync_out[2], locked[2]};
                n_cmp++;
                if (obs !== ex) begin
                    n_bad++; $display("FAIL loss p%0d k%0d vld/sync/lock got %b want %b", p, k, obs, ex);
                end
                if (p == 6 && k == 0) begin
                    n_cmp++;
                    if (loss_cnt[47:32] !== 16'd1) begin
                        n_bad++; $display("FAIL loss_cnt_on_drop got %0d want 1", loss_cnt[47:32]);
                    end
                end
            end
        end
        drive(2, 8'h00, 1'b0);
        n_cmp++;
        if (loss_cnt[47:32] !== 16'd1) begin
            n_bad++; $display("FAIL loss_cnt_after_relock got %0d want 1", loss_cnt[47:32]);
        end
    endtask

    // ch3: false 0x47 at index 50, true packets from index 100; lock lands on index 664.
    task automatic test_false_sync();
        logic [7:0] d;
        logic [2:0] obs, ex;
        logic       ev, tru;
        for (int i = 0; i <= 1100; i++) begin
            tru = (i >= 100) && ((i - 100) % 188 == 0);
            d   = (i == 50 || tru) ? 8'h47 : pay(i + 11000);
            drive(3, d, 1'b1);
            tick();
            ev  = (i >= 664);
            ex  = {ev, ev && tru, ev};
            obs = {valid_out[3], sync_out[3], locked[3]};
            n_cmp++;
            if (obs !== ex) begin
                n_bad++; $display("FAIL false_sync i%0d vld/sync/lock got %b want %b", i, obs, ex);
            end
        end
        drive(3, 8'h00, 1'b0);
    endtask

    // All channels mid-packet, async reset, then ch0..2 relock from a fresh stream.
    task automatic test_reset_mid();
        logic [7:0] d;
        logic [2:0] obs, ex;
        logic       ev;
        for (int k = 0; k < 60; k++) begin
            for (int c = 0; c < 3; c++) begin
                drive(c, (k == 0) ? 8'h47 : pay(k + c * 100), 1'b1);
            end
            drive(3, pay(k + 900), 1'b1);
            tick();
            for (int c = 0; c < 4; c++) begin
                ex  = {1'b1, (c < 3) && (k == 0), 1'b1};
                obs = {valid_out[c], sync_out[c], locked[c]};
                n_cmp++;
                if (obs !== ex) begin
                    n_bad++; $display("FAIL pre_reset ch%0d k%0d vld/sync/lock got %b want %b", c, k, obs, ex);
                end
            end
        end
        n_cmp++;
        if (loss_cnt[47:32] !== 16'd1) begin
            n_bad++; $display("FAIL pre_reset_loss got %0d want 1", loss_cnt[47:32]);
        end
        #3 rst_n = 1'b0;
        #1;
        n_cmp++; if (valid_out !== 4'h0) begin n_bad++; $display("FAIL midrst_valid got %h want 0", valid_out); end
        n_cmp++; if (sync_out !== 4'h0) begin n_bad++; $display("FAIL midrst_sync got %h want 0", sync_out); end
        n_cmp++; if (locked !== 4'h0) begin n_bad++; $display("FAIL midrst_locked got %h want 0", locked); end
        n_cmp++; if (ts_out !== 32'h0) begin n_bad++; $display("FAIL midrst_ts got %h want 0", ts_out); end
        n_cmp++; if (loss_cnt !== 64'h0) begin n_bad++; $display("FAIL midrst_loss got %h want 0", loss_cnt); end
        byte_valid = '0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        for (int p = 0; p < 4; p++) begin
            for (int k = 0; k < ((p == 3) ? 10 : 188); k++) begin
                for (int c = 0; c < 3; c++) begin
                    d = (k == 0) ? 8'h47 : pay(p * 188 + k + c * 50);
                    drive(c, d, 1'b1);
                end
                tick();
                ev = (p >= 2);
                for (int c = 0; c < 4; c++) begin
                    ex  = (c < 3) ? {ev, ev && (k == 0), ev} : 3'b000;
                    obs = {valid_out[c], sync_out[c], locked[c]};
                    n_cmp++;
                    if (obs !== ex) begin
                        n_bad++; $display("FAIL relock ch%0d p%0d k%0d vld/sync/lock got %b want %b", c, p, k, obs, ex);
                    end
                end
            end
        end
        for (int c = 0; c < 3; c++) drive(c, 8'h00, 1'b0);
        n_cmp++;
        if (loss_cnt !== 64'h0) begin
            n_bad++; $display("FAIL relock_loss got %h want 0", loss_cnt);
        end
    endtask

    // ch3: 204-byte packets with ~30% idle slots; mode_204 toggled after lock has no effect.
    task automatic test_204_gaps();
        logic [7:0] d, last_ts;
        logic [2:0] obs, ex;
        logic       ev, lk;
        int         j, cyc;
        j = 0; cyc = 0; lk = 1'b0; last_ts = 8'h00;
        mode_204 = 1'b1;
        while (j < 1020 && cyc < 4000) begin
            cyc++;
            if ($urandom_range(0, 9) < 3) begin
                drive(3, 8'h47, 1'b0);
                tick();
                ex  = {1'b0, 1'b0, lk};
                obs = {valid_out[3], sync_out[3], locked[3]};
                n_cmp++;
                if (obs !== ex) begin
                    n_bad++; $display("FAIL m204_idle j%0d vld/sync/lock got %b want %b", j, obs, ex);
                end
                if (lk) begin
                    n_cmp++;
                    if (ts_out[31:24] !== last_ts) begin
                        n_bad++; $display("FAIL m204_hold j%0d got %h want %h", j, ts_out[31:24], last_ts);
                    end
                end
            end else begin
                d = (j % 204 == 0) ? 8'h47 : pay(j + 20000);
                if (j >= 500) mode_204 = 1'((j / 50) % 2);
                drive(3, d, 1'b1);
                tick();
                ev  = (j >= 408);
                lk  = ev;
                ex  = {ev, ev && (j % 204 == 0), ev};
                obs = {valid_out[3], sync_out[3], locked[3]};
                n_cmp++;
                if (obs !== ex) begin
                    n_bad++; $display("FAIL m204 j%0d vld/sync/lock got %b want %b", j, obs, ex);
                end
                if (ev) begin
                    n_cmp++;
                    if (ts_out[31:24] !== d) begin
                        n_bad++; $display("FAIL m204_ts j%0d got %h want %h", j, ts_out[31:24], d);
                    end
                    last_ts = d;
                end
                j++;
            end
        end
        drive(3, 8'h00, 1'b0);
        n_cmp++;
        if (j != 1020) begin
            n_bad++; $display("FAIL m204_budget bytes got %0d want 1020", j);
        end
    endtask

    initial begin
        test_reset();
        test_clean_188();
        test_flywheel();
        test_loss_relock();
        test_false_sync();
        test_reset_mid();
        test_204_gaps();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog sim time exceeded, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
